// File: rtl/dwc_upconv_wchan_packer_pkg.sv
// Shared definitions for the W-channel upsizing packer: FSM encoding, byte-count
// derivations and the narrow-lane offset helper.
package dwc_upconv_wchan_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_DRAIN = 2'd2
    } pack_state_t;

    localparam int PTR_W = 6;
    localparam int CNT_W = 8;

    function automatic int bytes_of(input int width_bits);
        return width_bits / 8;
    endfunction

    // Narrow input lane that feeds a given wide byte position.
    function automatic int lane_offset(input int byte_idx, input int in_bytes);
        return byte_idx & (in_bytes - 1);
    endfunction

    function automatic logic [PTR_W-1:0] size_mask(input logic [2:0] size);
        return PTR_W'((8'd1 << size) - 8'd1);
    endfunction

endpackage

// File: rtl/dwc_upconv_wchan_lane_merge.sv
// Combinational placement of one narrow W beat into the wide pack word at the
// current byte pointer; strobes of the selected lanes are OR-ed into the pack strobe.
module dwc_upconv_wchan_lane_merge
    import dwc_upconv_wchan_packer_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = 32,
    parameter int DATA_WIDTH_OUT = 64
) (
    input  logic [DATA_WIDTH_OUT-1:0]   pack_data,
    input  logic [DATA_WIDTH_OUT/8-1:0] pack_strb,
    input  logic [DATA_WIDTH_IN-1:0]    beat_data,
    input  logic [DATA_WIDTH_IN/8-1:0]  beat_strb,
    input  logic [PTR_W-1:0]            ptr,
    input  logic [2:0]                  size,
    output logic [DATA_WIDTH_OUT-1:0]   merged_data,
    output logic [DATA_WIDTH_OUT/8-1:0] merged_strb
);

    localparam int IN_BYTES  = bytes_of(DATA_WIDTH_IN);
    localparam int OUT_BYTES = bytes_of(DATA_WIDTH_OUT);

    logic [PTR_W-1:0] beat_mask;
    assign beat_mask = size_mask(size);

    genvar gi;
    generate
        for (gi = 0; gi < OUT_BYTES; gi++) begin : g_byte
            localparam int               LANE = lane_offset(gi, IN_BYTES);
            localparam logic [PTR_W-1:0] IDX  = PTR_W'(gi);
            logic hit;

            // A wide byte belongs to this beat when it sits in the size-aligned window at ptr.
            assign hit = ((IDX & ~beat_mask) == ptr);
            assign merged_data[8*gi +: 8] = hit ? beat_data[8*LANE +: 8] : pack_data[8*gi +: 8];
            assign merged_strb[gi]        = pack_strb[gi] | (hit & beat_strb[LANE]);
        end
    endgenerate

endmodule

// File: rtl/dwc_upconv_wchan_packer.sv
// W-channel upsizer: packs narrow write beats into wide beats under a held command.
// Define DWC_UPCONV_WCHAN_USER_EN to forward WUSER of the last narrow beat per wide beat.
module dwc_upconv_wchan_packer
    import dwc_upconv_wchan_packer_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = 32,
    parameter int DATA_WIDTH_OUT = 64,
    parameter int USER_WIDTH     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hold_reg_empty,
    output logic                        get_next_data,
    input  logic [5:0]                  cmd_addr,
    input  logic [2:0]                  cmd_size,
    input  logic [7:0]                  cmd_wlen_mst,
    input  logic                        cmd_fixed,
    input  logic [DATA_WIDTH_IN-1:0]    s_wdata,
    input  logic [DATA_WIDTH_IN/8-1:0]  s_wstrb,
    input  logic [USER_WIDTH-1:0]       s_wuser,
    input  logic                        s_wlast,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    output logic [DATA_WIDTH_OUT-1:0]   m_wdata,
    output logic [DATA_WIDTH_OUT/8-1:0] m_wstrb,
    output logic [USER_WIDTH-1:0]       m_wuser,
    output logic                        m_wlast,
    output logic                        m_wvalid,
    input  logic                        m_wready
);

    localparam int               OUT_BYTES = bytes_of(DATA_WIDTH_OUT);
    localparam logic [PTR_W-1:0] OUT_MASK  = PTR_W'(OUT_BYTES - 1);

    pack_state_t state_reg, state_next;
    logic        get_next_data_reg, get_next_data_next;
    logic        load_cmd;

    logic [PTR_W-1:0]            ptr_reg;
    logic [CNT_W-1:0]            out_cnt_reg;
    logic [2:0]                  size_reg;
    logic                        fixed_reg;
    logic [7:0]                  wlen_reg;
    logic [DATA_WIDTH_OUT-1:0]   pack_data_reg;
    logic [DATA_WIDTH_OUT/8-1:0] pack_strb_reg;
    logic [DATA_WIDTH_OUT-1:0]   m_wdata_reg;
    logic [DATA_WIDTH_OUT/8-1:0] m_wstrb_reg;
    logic                        m_wlast_reg;
    logic                        m_wvalid_reg;

    logic [DATA_WIDTH_OUT-1:0]   merged_data;
    logic [DATA_WIDTH_OUT/8-1:0] merged_strb;
    logic [PTR_W-1:0]            beat_step;
    logic [PTR_W-1:0]            ptr_adv;
    logic                        accept;
    logic                        flush;

    // Stall only when the output register is full and not draining this cycle.
    assign s_wready  = (state_reg == ST_PACK) && !(m_wvalid_reg && !m_wready);
    assign accept    = s_wvalid && s_wready;
    assign beat_step = PTR_W'(8'd1 << size_reg);
    assign ptr_adv   = (ptr_reg + beat_step) & OUT_MASK;
    assign flush     = accept && ((ptr_adv == '0) || fixed_reg || s_wlast);

    dwc_upconv_wchan_lane_merge #(
        .DATA_WIDTH_IN  (DATA_WIDTH_IN),
        .DATA_WIDTH_OUT (DATA_WIDTH_OUT)
    ) u_lane_merge (
        .pack_data   (pack_data_reg),
        .pack_strb   (pack_strb_reg),
        .beat_data   (s_wdata),
        .beat_strb   (s_wstrb),
        .ptr         (ptr_reg),
        .size        (size_reg),
        .merged_data (merged_data),
        .merged_strb (merged_strb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            get_next_data_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            get_next_data_reg <= get_next_data_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        get_next_data_next = 1'b0;
        load_cmd           = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!hold_reg_empty) begin
                    get_next_data_next = 1'b1;
                    load_cmd           = 1'b1;
                    state_next         = ST_PACK;
                end
            end
            ST_PACK: begin
                if (accept && s_wlast) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (m_wvalid_reg && m_wready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg       <= '0;
            out_cnt_reg   <= '0;
            size_reg      <= '0;
            fixed_reg     <= 1'b0;
            wlen_reg      <= '0;
            pack_data_reg <= '0;
            pack_strb_reg <= '0;
            m_wdata_reg   <= '0;
            m_wstrb_reg   <= '0;
            m_wlast_reg   <= 1'b0;
            m_wvalid_reg  <= 1'b0;
        end else begin
            if (load_cmd) begin
                ptr_reg       <= cmd_addr & OUT_MASK & ~size_mask(cmd_size);
                out_cnt_reg   <= '0;
                size_reg      <= cmd_size;
                fixed_reg     <= cmd_fixed;
                wlen_reg      <= cmd_wlen_mst;
                pack_strb_reg <= '0;
            end
            if (accept) begin
                pack_data_reg <= merged_data;
                pack_strb_reg <= flush ? '0 : merged_strb;
                if (!fixed_reg) begin
                    ptr_reg <= ptr_adv;
                end
            end
            // A narrow s_wlast forces wlast even if the wide count disagrees.
            if (flush) begin
                m_wdata_reg  <= merged_data;
                m_wstrb_reg  <= merged_strb;
                m_wlast_reg  <= (out_cnt_reg == wlen_reg) || s_wlast;
                out_cnt_reg  <= out_cnt_reg + CNT_W'(1);
                m_wvalid_reg <= 1'b1;
            end else if (m_wready) begin
                m_wvalid_reg <= 1'b0;
            end
        end
    end

`ifdef DWC_UPCONV_WCHAN_USER_EN
    logic [USER_WIDTH-1:0] m_wuser_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wuser_reg <= '0;
        end else if (flush) begin
            m_wuser_reg <= s_wuser;
        end
    end

    assign m_wuser = m_wuser_reg;
`else
    logic unused_wuser;
    assign unused_wuser = ^s_wuser;
    assign m_wuser      = '0;
`endif

    assign get_next_data = get_next_data_reg;
    assign m_wdata       = m_wdata_reg;
    assign m_wstrb       = m_wstrb_reg;
    assign m_wlast       = m_wlast_reg;
    assign m_wvalid      = m_wvalid_reg;

endmodule
